// File: rtl/axi_lite_arbiter_2to1.sv
// rtl/axi_lite_arbiter_2to1.sv - 2:1 AXI4-Lite arbiter, one outstanding transaction, round-robin grant
// Optional: define AXI_ARB_FIXED_PRIORITY_EN for fixed priority s0W > s0R > s1W > s1R.
`timescale 1ns/1ps
module axi_lite_arbiter_2to1 #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [2*C_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [5:0]                        s_axi_awprot,
    input  logic [1:0]                        s_axi_awvalid,
    output logic [1:0]                        s_axi_awready,
    input  logic [2*C_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [2*(C_AXI_DATA_WIDTH/8)-1:0] s_axi_wstrb,
    input  logic [1:0]                        s_axi_wvalid,
    output logic [1:0]                        s_axi_wready,
    output logic [3:0]                        s_axi_bresp,
    output logic [1:0]                        s_axi_bvalid,
    input  logic [1:0]                        s_axi_bready,
    input  logic [2*C_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [5:0]                        s_axi_arprot,
    input  logic [1:0]                        s_axi_arvalid,
    output logic [1:0]                        s_axi_arready,
    output logic [2*C_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [3:0]                        s_axi_rresp,
    output logic [1:0]                        s_axi_rvalid,
    input  logic [1:0]                        s_axi_rready,
    output logic [C_AXI_ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]       m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0]     m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    output logic                              arb_busy,
    output logic [1:0]                        arb_grant
);

    localparam int A = C_AXI_ADDR_WIDTH;
    localparam int D = C_AXI_DATA_WIDTH;
    localparam int S = C_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [3:0] req;
    logic [1:0] base;
    logic [1:0] idx;
    logic [1:0] pick;
    logic       pick_vld;
    logic       g;
    logic       aw_hs;
    logic       w_hs;

    // Source index order: 0=s0W, 1=s0R, 2=s1W, 3=s1R; grant is {is_read, slot} = {idx[0], idx[1]}.
    assign req = {s_axi_arvalid[1], s_axi_awvalid[1] | s_axi_wvalid[1],
                  s_axi_arvalid[0], s_axi_awvalid[0] | s_axi_wvalid[0]};
    assign g         = grant_q[0];
    assign arb_grant = grant_q;
    assign arb_busy  = (state_q != IDLE);

`ifdef AXI_ARB_FIXED_PRIORITY_EN
    assign base = 2'd0;
`else
    logic [1:0] ptr_q, ptr_d;

    assign base = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == WR_RESP && m_axi_bvalid && m_axi_bready) ||
            (state_q == RD_RESP && m_axi_rvalid && m_axi_rready)) begin
            ptr_d = {grant_q[0], grant_q[1]} + 2'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        idx      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = base + 2'(k);
            if (!pick_vld && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bresp   = '0;
        s_axi_bvalid  = '0;
        s_axi_arready = '0;
        s_axi_rdata   = '0;
        s_axi_rresp   = '0;
        s_axi_rvalid  = '0;
        m_axi_awaddr  = '0;
        m_axi_awprot  = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arprot  = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        // Outputs are forced quiet during reset even if the state register still holds a busy state.
        if (!areset && state_q != IDLE) begin
            m_axi_awaddr = s_axi_awaddr[g*A +: A];
            m_axi_awprot = s_axi_awprot[g*3 +: 3];
            m_axi_wdata  = s_axi_wdata[g*D +: D];
            m_axi_wstrb  = s_axi_wstrb[g*S +: S];
            m_axi_araddr = s_axi_araddr[g*A +: A];
            m_axi_arprot = s_axi_arprot[g*3 +: 3];
        end

        if (!areset) begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_d = {pick[0], pick[1]};
                        state_d = pick[0] ? RD_REQ : WR_REQ;
                    end
                end
                WR_REQ: begin
                    m_axi_awvalid    = s_axi_awvalid[g] & ~aw_done_q;
                    m_axi_wvalid     = s_axi_wvalid[g] & ~w_done_q;
                    s_axi_awready[g] = m_axi_awready & ~aw_done_q;
                    s_axi_wready[g]  = m_axi_wready & ~w_done_q;
                    aw_hs = s_axi_awvalid[g] & ~aw_done_q & m_axi_awready;
                    w_hs  = s_axi_wvalid[g] & ~w_done_q & m_axi_wready;
                    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_RESP;
                    end else begin
                        aw_done_d = aw_done_q | aw_hs;
                        w_done_d  = w_done_q | w_hs;
                    end
                end
                WR_RESP: begin
                    s_axi_bvalid[g]         = m_axi_bvalid;
                    s_axi_bresp[g*2 +: 2]   = m_axi_bresp;
                    m_axi_bready            = s_axi_bready[g];
                    if (m_axi_bvalid && s_axi_bready[g]) state_d = IDLE;
                end
                RD_REQ: begin
                    m_axi_arvalid    = s_axi_arvalid[g];
                    s_axi_arready[g] = m_axi_arready;
                    if (s_axi_arvalid[g] && m_axi_arready) state_d = RD_RESP;
                end
                RD_RESP: begin
                    s_axi_rvalid[g]       = m_axi_rvalid;
                    s_axi_rdata[g*D +: D] = m_axi_rdata;
                    s_axi_rresp[g*2 +: 2] = m_axi_rresp;
                    m_axi_rready          = s_axi_rready[g];
                    if (m_axi_rvalid && s_axi_rready[g]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            grant_q   <= 2'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// tb/tb_axi_lite_arbiter_2to1.sv - directed self-checking bench for axi_lite_arbiter_2to1
`timescale 1ns/1ps
module tb_axi_lite_arbiter_2to1;

    logic        aclk = 1'b0;
    logic        areset;
    logic [63:0] s_axi_awaddr;
    logic [5:0]  s_axi_awprot;
    logic [1:0]  s_axi_awvalid, s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic [1:0]  s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_bresp;
    logic [1:0]  s_axi_bvalid, s_axi_bready;
    logic [63:0] s_axi_araddr;
    logic [5:0]  s_axi_arprot;
    logic [1:0]  s_axi_arvalid, s_axi_arready;
    logic [63:0] s_axi_rdata;
    logic [3:0]  s_axi_rresp;
    logic [1:0]  s_axi_rvalid, s_axi_rready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid, m_axi_rready;
    logic        arb_busy;
    logic [1:0]  arb_grant;

    int checks = 0;
    int passes = 0;

    always #5 aclk = ~aclk;

    axi_lite_arbiter_2to1 #(.C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .arb_busy(arb_busy), .arb_grant(arb_grant)
    );

    task automatic clear_inputs();
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = '0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = '0; s_axi_bready = '0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = '0; s_axi_rready = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        clear_inputs();
        s_axi_awvalid = 2'b11;
        s_axi_arvalid = 2'b11;
        repeat (2) @(negedge aclk);
        #1;
        checks++;
        if ({arb_busy, arb_grant} !== 3'b000)
            $display("FAIL reset_state: busy/grant=%b want 000", {arb_busy, arb_grant});
        else passes++;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
             s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 15'd0)
            $display("FAIL reset_handshakes: got %b want 0",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                      s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
        else passes++;
        @(negedge aclk);
        clear_inputs();
        areset = 1'b0;
        @(negedge aclk);
        #1;
        checks++;
        if (arb_busy !== 1'b0) $display("FAIL idle_no_req: busy=%b want 0", arb_busy);
        else passes++;
    endtask

    task automatic test_single_write();
        @(negedge aclk);
        s_axi_awaddr[31:0] = 32'h10; s_axi_awvalid = 2'b01;
        s_axi_wdata[31:0] = 32'hDEADBEEF; s_axi_wstrb[3:0] = 4'hF; s_axi_wvalid = 2'b01;
        #1;
        checks++;
        if ({m_axi_awvalid, arb_busy} !== 2'b00)
            $display("FAIL sw_latency: awvalid/busy=%b want 00", {m_axi_awvalid, arb_busy});
        else passes++;
        @(negedge aclk);
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        #1;
        checks++;
        if ({arb_busy, arb_grant, m_axi_awvalid, m_axi_wvalid, s_axi_awready, s_axi_wready} !== 9'b1_00_1_1_01_01)
            $display("FAIL sw_req: got %b want 100110101",
                     {arb_busy, arb_grant, m_axi_awvalid, m_axi_wvalid, s_axi_awready, s_axi_wready});
        else passes++;
        checks++;
        if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF})
            $display("FAIL sw_payload: addr=%h data=%h strb=%h want 10/deadbeef/f",
                     m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
        else passes++;
        @(negedge aclk);
        s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; s_axi_bready = 2'b01;
        #1;
        checks++;
        if ({s_axi_bvalid, s_axi_bresp, m_axi_bready, m_axi_awvalid} !== 8'b01_0000_1_0)
            $display("FAIL sw_bresp: got %b want 01000010",
                     {s_axi_bvalid, s_axi_bresp, m_axi_bready, m_axi_awvalid});
        else passes++;
        @(negedge aclk);
        m_axi_bvalid = 1'b0; s_axi_bready = 2'b00;
        #1;
        checks++;
        if ({arb_busy, s_axi_bvalid, arb_grant, m_axi_awaddr} !== {1'b0, 2'b00, 2'b00, 32'h0})
            $display("FAIL sw_back_idle: busy=%b bvalid=%b grant=%b awaddr=%h want 0/00/00/0",
                     arb_busy, s_axi_bvalid, arb_grant, m_axi_awaddr);
        else passes++;
    endtask

    task automatic test_w_before_aw();
        @(negedge aclk);
        s_axi_wdata[63:32] = 32'hA5A50001; s_axi_wstrb[7:4] = 4'h3; s_axi_wvalid = 2'b10;
        m_axi_wready = 1'b1; m_axi_awready = 1'b1;
        @(negedge aclk);
        #1;
        checks++;
        if ({arb_grant, m_axi_awvalid, m_axi_wvalid, s_axi_wready, s_axi_awready} !== 8'b01_0_1_10_10)
            $display("FAIL wa_first_w: got %b want 01011010",
                     {arb_grant, m_axi_awvalid, m_axi_wvalid, s_axi_wready, s_axi_awready});
        else passes++;
        checks++;
        if ({m_axi_wdata, m_axi_wstrb} !== {32'hA5A50001, 4'h3})
            $display("FAIL wa_wdata: data=%h strb=%h want a5a50001/3", m_axi_wdata, m_axi_wstrb);
        else passes++;
        @(negedge aclk);
        #1;
        checks++;
        if ({m_axi_wvalid, s_axi_wready, arb_busy} !== 4'b0_00_1)
            $display("FAIL wa_w_done: wvalid/wready/busy=%b want 0001", {m_axi_wvalid, s_axi_wready, arb_busy});
        else passes++;
        @(negedge aclk);
        s_axi_wvalid = 2'b00;
        s_axi_awaddr[63:32] = 32'h40; s_axi_awprot[5:3] = 3'b001; s_axi_awvalid = 2'b10;
        #1;
        checks++;
        if ({m_axi_awvalid, s_axi_awready, m_axi_awaddr, m_axi_awprot} !== {1'b1, 2'b10, 32'h40, 3'b001})
            $display("FAIL wa_late_aw: valid=%b ready=%b addr=%h prot=%b want 1/10/40/001",
                     m_axi_awvalid, s_axi_awready, m_axi_awaddr, m_axi_awprot);
        else passes++;
        @(negedge aclk);
        s_axi_awvalid = 2'b00; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10; s_axi_bready = 2'b11;
        #1;
        checks++;
        if ({s_axi_bvalid, s_axi_bresp, m_axi_bready} !== 7'b10_1000_1)
            $display("FAIL wa_bresp: got %b want 1010001", {s_axi_bvalid, s_axi_bresp, m_axi_bready});
        else passes++;
        @(negedge aclk);
        m_axi_bvalid = 1'b0; s_axi_bready = 2'b00;
        #1;
        checks++;
        if ({arb_busy, s_axi_bvalid} !== 3'b000)
            $display("FAIL wa_single_b: busy/bvalid=%b want 000", {arb_busy, s_axi_bvalid});
        else passes++;
    endtask

    task automatic test_read_stall();
        @(negedge aclk);
        s_axi_araddr[63:32] = 32'h24; s_axi_arprot[5:3] = 3'b010; s_axi_arvalid = 2'b10;
        s_axi_rready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            #1;
            checks++;
            if ({m_axi_arvalid, s_axi_arready, s_axi_rvalid, arb_grant, m_axi_araddr} !== {1'b1, 2'b00, 2'b00, 2'b11, 32'h24})
                $display("FAIL rd_stall_%0d: arvalid=%b arready=%b rvalid=%b grant=%b addr=%h want 1/00/00/11/24",
                         i, m_axi_arvalid, s_axi_arready, s_axi_rvalid, arb_grant, m_axi_araddr);
            else passes++;
        end
        @(negedge aclk);
        m_axi_arready = 1'b1;
        #1;
        checks++;
        if ({s_axi_arready, m_axi_arprot} !== 5'b10_010)
            $display("FAIL rd_arready: got %b want 10010", {s_axi_arready, m_axi_arprot});
        else passes++;
        @(negedge aclk);
        s_axi_arvalid = 2'b00; m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h12345678; m_axi_rresp = 2'b10;
        #1;
        checks++;
        if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp, m_axi_rready, s_axi_arready} !== {2'b10, 32'h12345678, 32'h0, 4'b1000, 1'b1, 2'b00})
            $display("FAIL rd_data: rvalid=%b rdata=%h rresp=%b rready=%b want 10/1234567800000000/1000/1",
                     s_axi_rvalid, s_axi_rdata, s_axi_rresp, m_axi_rready);
        else passes++;
        @(negedge aclk);
        m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; s_axi_rready = 2'b00;
        #1;
        checks++;
        if ({arb_busy, s_axi_rvalid} !== 3'b000)
            $display("FAIL rd_back_idle: busy/rvalid=%b want 000", {arb_busy, s_axi_rvalid});
        else passes++;
    endtask

    task automatic test_b_backpressure();
        @(negedge aclk);
        s_axi_awaddr[31:0] = 32'h80; s_axi_awvalid = 2'b01;
        s_axi_wdata[31:0] = 32'h0BADF00D; s_axi_wstrb[3:0] = 4'hC; s_axi_wvalid = 2'b01;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        @(negedge aclk);
        #1;
        checks++;
        if ({arb_grant, m_axi_awvalid, m_axi_wvalid, m_axi_wstrb} !== 8'b00_1_1_1100)
            $display("FAIL bp_req: got %b want 00111100", {arb_grant, m_axi_awvalid, m_axi_wvalid, m_axi_wstrb});
        else passes++;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            if (i == 0) begin
                s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
                m_axi_bvalid = 1'b1; m_axi_bresp = 2'b01; s_axi_bready = 2'b00;
                s_axi_araddr[63:32] = 32'h30; s_axi_arvalid = 2'b10;
            end
            #1;
            checks++;
            if ({m_axi_bready, s_axi_bvalid, s_axi_bresp, m_axi_arvalid, arb_busy} !== 9'b0_01_0001_0_1)
                $display("FAIL bp_hold_%0d: got %b want 001000101", i,
                         {m_axi_bready, s_axi_bvalid, s_axi_bresp, m_axi_arvalid, arb_busy});
            else passes++;
        end
        @(negedge aclk);
        s_axi_bready = 2'b01;
        #1;
        checks++;
        if (m_axi_bready !== 1'b1) $display("FAIL bp_release: bready=%b want 1", m_axi_bready);
        else passes++;
        @(negedge aclk);
        m_axi_bvalid = 1'b0; s_axi_bready = 2'b00;
        #1;
        checks++;
        if ({arb_busy, m_axi_arvalid} !== 2'b00)
            $display("FAIL bp_idle_gap: busy/arvalid=%b want 00", {arb_busy, m_axi_arvalid});
        else passes++;
        @(negedge aclk);
        m_axi_arready = 1'b1;
        #1;
        checks++;
        if ({m_axi_arvalid, arb_grant, m_axi_araddr} !== {1'b1, 2'b11, 32'h30})
            $display("FAIL bp_read_issue: arvalid=%b grant=%b addr=%h want 1/11/30",
                     m_axi_arvalid, arb_grant, m_axi_araddr);
        else passes++;
        @(negedge aclk);
        s_axi_arvalid = 2'b00; m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h55AA; s_axi_rready = 2'b10;
        #1;
        checks++;
        if ({s_axi_rvalid, m_axi_rready} !== 3'b10_1)
            $display("FAIL bp_read_resp: rvalid/rready=%b want 101", {s_axi_rvalid, m_axi_rready});
        else passes++;
        @(negedge aclk);
        m_axi_rvalid = 1'b0; m_axi_rdata = '0; s_axi_rready = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0] got[$];
        logic [1:0] exp_g[5];
        logic       prev_busy;
`ifdef AXI_ARB_FIXED_PRIORITY_EN
        exp_g = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`else
        exp_g = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
`endif
        areset = 1'b1;
        clear_inputs();
        s_axi_awvalid = 2'b11; s_axi_wvalid = 2'b11; s_axi_arvalid = 2'b11;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bvalid = 1'b1; m_axi_rvalid = 1'b1; s_axi_bready = 2'b11; s_axi_rready = 2'b11;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        prev_busy = 1'b0;
        for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
            @(negedge aclk);
            #1;
            if (arb_busy && !prev_busy) got.push_back(arb_grant);
            prev_busy = arb_busy;
        end
        checks++;
        if (got.size() != 5) $display("FAIL rr_count: grants=%0d want 5", got.size());
        else passes++;
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_g[i]) $display("FAIL rr_grant_%0d: got %b want %b", i, got[i], exp_g[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_write();
        areset = 1'b1;
        clear_inputs();
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        s_axi_awaddr[31:0] = 32'h44; s_axi_awvalid = 2'b01;
        s_axi_wdata[31:0] = 32'hCAFEF00D; s_axi_wstrb[3:0] = 4'hF; s_axi_wvalid = 2'b01;
        m_axi_awready = 1'b1;
        @(negedge aclk);
        #1;
        checks++;
        if ({arb_busy, m_axi_awvalid, m_axi_wvalid} !== 3'b111)
            $display("FAIL rm_req: busy/awvalid/wvalid=%b want 111", {arb_busy, m_axi_awvalid, m_axi_wvalid});
        else passes++;
        @(negedge aclk);
        #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, s_axi_awready, s_axi_wready} !== 6'b0_1_00_00)
            $display("FAIL rm_aw_done: got %b want 010000", {m_axi_awvalid, m_axi_wvalid, s_axi_awready, s_axi_wready});
        else passes++;
        areset = 1'b1;
        #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
             s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, m_axi_awaddr} !== 47'd0)
            $display("FAIL rm_in_reset: outputs not quiet, awvalid=%b wvalid=%b awready=%b awaddr=%h",
                     m_axi_awvalid, m_axi_wvalid, s_axi_awready, m_axi_awaddr);
        else passes++;
        @(negedge aclk);
        areset = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if ({arb_busy, arb_grant, m_axi_awvalid, m_axi_wvalid, s_axi_bvalid} !== 7'd0)
            $display("FAIL rm_after_reset: got %b want 0",
                     {arb_busy, arb_grant, m_axi_awvalid, m_axi_wvalid, s_axi_bvalid});
        else passes++;
        @(negedge aclk);
        s_axi_awaddr[31:0] = 32'h44; s_axi_awvalid = 2'b01;
        s_axi_wdata[31:0] = 32'hCAFEF00D; s_axi_wstrb[3:0] = 4'hF; s_axi_wvalid = 2'b01;
        s_axi_araddr[63:32] = 32'h50; s_axi_arvalid = 2'b10;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        @(negedge aclk);
        #1;
        checks++;
        if ({arb_grant, m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata} !== {2'b00, 1'b1, 1'b1, 32'h44, 32'hCAFEF00D})
            $display("FAIL rm_fresh_write: grant=%b awvalid=%b wvalid=%b addr=%h data=%h want 00/1/1/44/cafef00d",
                     arb_grant, m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata);
        else passes++;
        @(negedge aclk);
        s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; s_axi_bready = 2'b01;
        #1;
        checks++;
        if ({s_axi_bvalid, s_axi_bresp, m_axi_bready} !== 7'b01_0000_1)
            $display("FAIL rm_fresh_b: got %b want 0100001", {s_axi_bvalid, s_axi_bresp, m_axi_bready});
        else passes++;
        @(negedge aclk);
        m_axi_bvalid = 1'b0; s_axi_bready = 2'b00;
        #1;
        checks++;
        if ({arb_busy, s_axi_bvalid} !== 3'b000)
            $display("FAIL rm_fresh_done: busy/bvalid=%b want 000", {arb_busy, s_axi_bvalid});
        else passes++;
    endtask

    initial begin
        areset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_w_before_aw();
        test_read_stall();
        test_b_backpressure();
        test_round_robin();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
